// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch-state encoding,
// instruction word geometry and the HALT opcode.
package instr_fetch_unit_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // read request outstanding toward instruction memory
    ST_HOLD  = 2'd1,  // instruction presented to the control unit
    ST_HALT  = 2'd2   // fetch stopped after a HALT opcode was delivered
  } fetch_state_e;

  // True when the word carries the HALT opcode in its opcode field.
  function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// buffers the returned word in its output register until the control unit
// accepts it, and follows redirects (discarding an in-flight read if needed).
// Build option: define IFU_HALT_DETECT_EN to stop fetching after a HALT
// opcode (4'b1111) has been delivered; without it HALT is an ordinary word.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_valid,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   held_addr_q, held_addr_d;   // address of a read being discarded
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                discard_q, discard_d;       // in-flight read must be dropped
  logic                run_q, run_d;               // low only in the cycle reset releases

  // Requests start the first clock after reset and only in FETCH. While a
  // discarded read is still in flight the old address stays on the bus.
  assign mem_req     = run_q && (state_q == ST_FETCH);
  assign mem_addr    = discard_q ? held_addr_q : pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef IFU_HALT_DETECT_EN
  assign halted      = (state_q == ST_HALT);
`else
  assign halted      = 1'b0;
`endif

  // Next-state logic: redirect wins over every other event in every state.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    held_addr_d = held_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    discard_d   = discard_q;
    run_d       = 1'b1;

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_req && !mem_valid) begin
            // Read still in flight: keep the request up until it returns,
            // remembering the address it was issued at.
            discard_d = 1'b1;
            if (!discard_q) held_addr_d = pc_q;
          end else begin
            // Data returning now (or nothing issued) is simply dropped.
            discard_d = 1'b0;
          end
        end else if (mem_req && mem_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
`ifdef IFU_HALT_DETECT_EN
          state_d = is_halt_word(instr_q) ? ST_HALT : ST_FETCH;
`else
          state_d = ST_FETCH;
`endif
        end
      end

`ifdef IFU_HALT_DETECT_EN
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end
      end
`endif

      default: state_d = ST_FETCH;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      held_addr_q <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      discard_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      held_addr_q <= held_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      discard_q   <= discard_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A transaction-level model tracks
// which address must be delivered next, whether a read is being discarded and
// whether fetch is halted; a memory responder answers requests with random or
// fixed latency and injects stray mem_valid pulses.
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;
`ifdef IFU_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction memory contents and responder state.
  logic [15:0] mem [256];
  bit          act;        // responder has an accepted request in progress
  int          cnt, wn;    // cycles waited / cycles to wait
  int          lat_mode;   // <0 random latency 0..3, else fixed
  int          sp_mode;    // stray mem_valid when idle: 0 never, 1 random, 2 always

  // Reference model.
  bit          m_started, m_valid, m_disc, m_halt;
  logic [7:0]  m_next, m_held;

  // Last sampled outputs, for scenario checks.
  bit          seen_valid, seen_req;
  logic [7:0]  seen_pc;
  logic [15:0] seen_instr;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] rpc);
    bit cap, acc, mreq;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (mem_req) begin
      if (!act) begin
        act = 1'b1;
        cnt = 0;
        wn  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      mem_valid = (cnt == wn);
      mem_rdata = mem_valid ? mem[mem_addr] : 16'($urandom);
    end else begin
      act       = 1'b0;
      mem_valid = (sp_mode == 2) || (sp_mode == 1 && $urandom_range(0, 5) == 0);
      mem_rdata = 16'($urandom);
    end

    @(negedge clk);
    mreq = m_started && !m_valid && !m_halt;
    check("mem_req", mem_req, mreq);
    check("instr_valid", instr_valid, m_valid);
    check("halted", halted, m_halt);
    if (m_valid) begin
      check("instr_pc", instr_pc, m_next);
      check("instr", instr, mem[m_next]);
    end
    if (mreq) check("mem_addr", mem_addr, m_disc ? m_held : m_next);
    seen_valid = instr_valid;
    seen_req   = mem_req;
    seen_pc    = instr_pc;
    seen_instr = instr;

    // Model: what the next cycle must look like.
    acc = m_valid && rdy;
    cap = 1'b0;
    if (mreq && mem_valid) begin
      cap    = !m_disc && !rv;
      m_disc = 1'b0;
    end else if (mreq && rv) begin
      if (!m_disc) m_held = m_next;
      m_disc = 1'b1;
    end
    if (acc && !rv) begin
      if (HALT_EN && mem[m_next][15:12] == 4'hF) m_halt = 1'b1;
      m_next = m_next + 8'd1;
    end
    if (rv) begin
      m_next = rpc;
      m_halt = 1'b0;
    end
    m_valid   = cap || (m_valid && !rdy && !rv);
    m_started = 1'b1;

    if (mem_req && mem_valid) act = 1'b0;
    else if (mem_req) cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Assert reset (possibly mid-transaction) with mem_valid high throughout.
  task automatic apply_reset();
    rst            = 1'b1;
    act            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    mem_valid      = 1'b1;
    mem_rdata      = 16'hBEEF;
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_started = 1'b0;
    m_valid   = 1'b0;
    m_disc    = 1'b0;
    m_halt    = 1'b0;
    m_next    = RESET_PC;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  pcs[$];
    int          cycs[$];
    bit          found, bad10;

    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      mem[i] = w;
    end
    mem[8'h30] = 16'h1234;
    mem[8'h50] = 16'hF000;
    mem[8'h90] = 16'hF123;

    lat_mode       = 0;
    sp_mode        = 0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    mem_valid      = 1'b0;
    mem_rdata      = 16'h0000;
    @(posedge clk);
    #1;
    apply_reset();

    // Zero-wait memory, always ready: pcs 0,1,2,3 two cycles apart.
    sp_mode = 2;
    step(1'b1, 1'b0, 8'h00);
    sp_mode = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (seen_valid) begin
        pcs.push_back(seen_pc);
        cycs.push_back(cyc);
      end
    end
    check("seq_count", pcs.size() >= 4, 1'b1);
    if (pcs.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("seq_pc", pcs[k], k);
        if (k > 0) check("seq_spacing", cycs[k] - cycs[k-1], 2);
      end
    end

    // Back-pressure: 16'h1234 held for 5 cycles, no request meanwhile.
    step(1'b0, 1'b1, 8'h30);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 8'h00);
      found = seen_valid;
    end
    check("stall_reach", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check("stall_instr", seen_instr, 16'h1234);
      check("stall_req", seen_req, 1'b0);
    end
    step(1'b1, 1'b0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 8'h00);
      found = seen_valid;
    end
    check("resume_reach", found, 1'b1);
    check("resume_pc", seen_pc, 8'h31);

    // Wrap: redirect to 8'hFF, next deliveries FF then 00.
    step(1'b1, 1'b1, 8'hFF);
    pcs.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (seen_valid) pcs.push_back(seen_pc);
    end
    check("wrap_count", pcs.size() >= 2, 1'b1);
    if (pcs.size() >= 2) begin
      check("wrap_pc0", pcs[0], 8'hFF);
      check("wrap_pc1", pcs[1], 8'h00);
    end

    // Redirect to 8'h40 while the read at 8'h10 is in flight (3-cycle memory).
    step(1'b1, 1'b1, 8'h10);
    lat_mode = 3;
    check("disc_pre", mem_req && (mem_addr == 8'h10), 1'b1);
    step(1'b1, 1'b1, 8'h40);
    bad10 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (seen_valid && seen_pc == 8'h10) bad10 = 1'b1;
      found = seen_valid;
    end
    check("disc_no_10", bad10, 1'b0);
    check("disc_reach", found, 1'b1);
    check("disc_pc", seen_pc, 8'h40);

    // HALT opcode at 8'h50, then redirect to 8'h20.
    lat_mode = 0;
    step(1'b1, 1'b1, 8'h50);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 8'h00);
      found = seen_valid;
    end
    check("halt_reach", found, 1'b1);
    check("halt_word", seen_instr, 16'hF000);
    check("halt_pc", seen_pc, 8'h50);
    check("halt_flag", halted, HALT_EN);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    check("halt_flag_held", halted, HALT_EN);
    step(1'b0, 1'b1, 8'h20);
    check("unhalt_flag", halted, 1'b0);
    check("unhalt_req", mem_req, 1'b1);
    check("unhalt_addr", mem_addr, 8'h20);

    // Randomised traffic.
    lat_mode = -1;
    sp_mode  = 1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 8'($urandom));
    end

    // Reset in the middle of an outstanding read.
    lat_mode = 3;
    sp_mode  = 0;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 8'h00);
      found = act;
    end
    check("rst_mid_reach", found, 1'b1);
    apply_reset();
    sp_mode = 2;
    step(1'b1, 1'b0, 8'h00);
    sp_mode  = 0;
    lat_mode = 0;
    check("rst_first_req", mem_req, 1'b1);
    check("rst_first_addr", mem_addr, RESET_PC);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 8'h00);
      found = seen_valid;
    end
    check("rst_first_reach", found, 1'b1);
    check("rst_first_pc", seen_pc, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
